// File: rtl/mult_strm_issue.sv
// Streaming multiplier initiator: issues operand pairs under credit and multiplier backpressure,
// buffers results in a fall-through FIFO and drains them downstream.
module mult_strm_issue #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned RES_DEPTH = 16
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [63:0]      i_opnd_a,
  input  logic [63:0]      i_opnd_b,
  input  logic             i_opnd_vld,
  output logic             o_opnd_rdy,
  output logic [63:0]      o_mul_a,
  output logic [63:0]      o_mul_b,
  output logic             o_mul_vld,
  input  logic             i_mul_rdy,
  input  logic [63:0]      i_mul_res,
  input  logic             i_mul_vld,
  output logic [63:0]      o_res,
  output logic             o_res_vld,
  input  logic             i_res_rdy,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int unsigned PtrW  = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned FillW = $clog2(RES_DEPTH + 1);
  localparam logic [PtrW-1:0]  PtrLast   = PtrW'(RES_DEPTH - 1);
  localparam logic [FillW-1:0] FillFull  = FillW'(RES_DEPTH);
  localparam logic [CNT_W-1:0] CreditMax = CNT_W'(RES_DEPTH);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] credit_q, credit_d;
  logic             err_q, err_d;
  logic [63:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic             mul_vld_q, mul_vld_d;
  logic [63:0]      mem_q [RES_DEPTH];
  logic [63:0]      mem_d [RES_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FillW-1:0] fill_q, fill_d;

  logic start, opnd_rdy, xfer, pop, push, full, empty, arrived;

  always_comb begin
    empty    = (fill_q == '0);
    full     = (fill_q == FillFull);
    start    = (state_q == StIdle) && i_start;
    opnd_rdy = (state_q == StIssue) && (issued_q < cnt_q) && i_mul_rdy && (credit_q < CreditMax);
    xfer     = i_opnd_vld && opnd_rdy;
    pop      = !empty && i_res_rdy;
    // Results never stall: a push is dropped only when there is nowhere to put it.
    push     = i_mul_vld && (state_q != StIdle) && (!full || pop);
    arrived  = i_mul_vld && (inflight_q != '0);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    issued_d   = issued_q;
    retired_d  = retired_q;
    inflight_d = inflight_q;
    credit_d   = credit_q;
    err_d      = err_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_vld_d  = xfer;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;

    unique case (state_q)
      StIdle:  if (i_start) state_d = StIssue;
      StIssue: if (issued_q == cnt_q) state_d = StDrain;
      StDrain: if (retired_q == cnt_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      mul_a_d  = i_opnd_a;
      mul_b_d  = i_opnd_b;
      issued_d = issued_q + 1'b1;
    end
    if (pop) retired_d = retired_q + 1'b1;

    if (xfer && !pop) begin
      credit_d = credit_q + 1'b1;
    end else if (!xfer && pop && (credit_q != '0)) begin
      credit_d = credit_q - 1'b1;
    end

    if (xfer && !arrived) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!xfer && arrived) begin
      inflight_d = inflight_q - 1'b1;
    end

    if (i_mul_vld && ((state_q == StIdle) || (inflight_q == '0) || (full && !pop))) begin
      err_d = 1'b1;
    end

    if (push) begin
      mem_d[wr_ptr_q] = i_mul_res;
      wr_ptr_d        = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop) begin
      fill_d = fill_q + 1'b1;
    end else if (!push && pop) begin
      fill_d = fill_q - 1'b1;
    end

    // An accepted start wins over any bookkeeping in the same cycle.
    if (start) begin
      cnt_d      = i_cnt;
      issued_d   = '0;
      retired_d  = '0;
      inflight_d = '0;
      credit_d   = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      inflight_q <= '0;
      credit_q   <= '0;
      err_q      <= 1'b0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_vld_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      inflight_q <= inflight_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_vld_q  <= mul_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
    end
  end

  // Storage needs no reset; the head is gated while the FIFO is empty.
  always_ff @(posedge ck) begin
    mem_q <= mem_d;
  end

  always_comb begin
    o_opnd_rdy = opnd_rdy;
    o_mul_a    = mul_a_q;
    o_mul_b    = mul_b_q;
    o_mul_vld  = mul_vld_q;
    o_res_vld  = !empty;
    o_res      = empty ? '0 : mem_q[rd_ptr_q];
    o_busy     = (state_q != StIdle);
    o_done     = (state_q == StDone);
    o_err      = err_q;
  end

endmodule

// File: tb/tb_mult_strm_issue.sv
// Directed bench for mult_strm_issue with a fixed-latency multiplier model.
module tb_mult_strm_issue;

  localparam int Lat = 10;

  logic        ck = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_cnt;
  logic [63:0] i_opnd_a, i_opnd_b;
  logic        i_opnd_vld, o_opnd_rdy;
  logic [63:0] o_mul_a, o_mul_b;
  logic        o_mul_vld, i_mul_rdy;
  logic [63:0] i_mul_res;
  logic        i_mul_vld;
  logic [63:0] o_res;
  logic        o_res_vld, i_res_rdy, o_busy, o_done, o_err;

  int n_tests = 0;
  int n_fail  = 0;
  int n_xfer  = 0;
  int n_issue = 0;
  int n_done  = 0;
  logic [63:0] got_q[$];
  logic [63:0] opnd_base;
  logic        spur_vld;
  logic [63:0] pipe_res [Lat];
  logic [Lat-1:0] pipe_vld;
  logic [31:0] pat_a = 32'hB5A3_6C9D;
  logic [31:0] pat_b = 32'h6D2B_D5B6;

  always #5 ck = ~ck;

  assign i_opnd_a  = opnd_base + 64'(n_xfer);
  assign i_opnd_b  = i_opnd_a + 64'd1;
  assign i_mul_vld = pipe_vld[Lat-1] | spur_vld;
  assign i_mul_res = pipe_res[Lat-1];

  mult_strm_issue dut (
    .ck(ck), .rst(rst), .i_start(i_start), .i_cnt(i_cnt),
    .i_opnd_a(i_opnd_a), .i_opnd_b(i_opnd_b), .i_opnd_vld(i_opnd_vld),
    .o_opnd_rdy(o_opnd_rdy), .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .o_mul_vld(o_mul_vld),
    .i_mul_rdy(i_mul_rdy), .i_mul_res(i_mul_res), .i_mul_vld(i_mul_vld),
    .o_res(o_res), .o_res_vld(o_res_vld), .i_res_rdy(i_res_rdy),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  // Multiplier model (latency Lat, reset with the DUT) plus transfer/pop monitors.
  always @(posedge ck) begin
    if (i_opnd_vld && o_opnd_rdy) n_xfer <= n_xfer + 1;
    if (o_mul_vld) n_issue <= n_issue + 1;
    if (o_done) n_done <= n_done + 1;
    if (o_res_vld && i_res_rdy) got_q.push_back(o_res);
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[Lat-2:0], o_mul_vld};
      pipe_res[0] <= o_mul_a * o_mul_b;
      for (int i = 1; i < Lat; i++) pipe_res[i] <= pipe_res[i-1];
    end
  end

  function automatic logic [63:0] exp_prod(input logic [63:0] base, input int idx);
    logic [63:0] a;
    a = base + 64'(idx);
    return a * (a + 64'd1);
  endfunction

  task automatic start_job(input logic [31:0] c);
    @(negedge ck);
    i_start = 1'b1;
    i_cnt   = c;
    @(negedge ck);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input bit jitter, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < maxc && !ok; c++) begin
      @(negedge ck);
      if (jitter) begin
        i_opnd_vld = pat_a[c % 32];
        i_res_rdy  = pat_b[c % 32];
      end
      if (o_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge ck);
    n_tests++;
    if ({o_busy, o_done, o_err, o_mul_vld, o_opnd_rdy, o_res_vld} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {o_busy, o_done, o_err, o_mul_vld, o_opnd_rdy, o_res_vld});
    end
    n_tests++;
    if ({o_mul_a, o_mul_b, o_res} !== 192'b0) begin
      n_fail++;
      $display("FAIL reset_data: got a=%0h b=%0h res=%0h want 0", o_mul_a, o_mul_b, o_res);
    end
    rst = 1'b0;
    @(negedge ck);
  endtask

  task automatic test_basic();
    int x0, g0, d0, first, last, nv;
    bit ok;
    logic [63:0] got;
    opnd_base = 64'h0000_0001_0000_0005;
    i_opnd_vld = 1'b1; i_mul_rdy = 1'b1; i_res_rdy = 1'b1;
    x0 = n_xfer; g0 = got_q.size(); d0 = n_done;
    first = -1; last = -1; nv = 0; ok = 1'b0;
    start_job(4);
    for (int c = 0; c < 80 && !ok; c++) begin
      if (o_mul_vld) begin
        if (first < 0) first = c;
        last = c;
        nv++;
      end
      if (o_done) ok = 1'b1;
      else @(negedge ck);
    end
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: got no done want done"); end
    n_tests++;
    if (nv != 4) begin n_fail++; $display("FAIL basic_strobes: got %0d want 4", nv); end
    n_tests++;
    if (last - first != 3) begin
      n_fail++; $display("FAIL basic_consecutive: got span %0d want 3", last - first);
    end
    n_tests++;
    if (got_q.size() - g0 != 4) begin
      n_fail++; $display("FAIL basic_nres: got %0d want 4", got_q.size() - g0);
    end
    for (int j = 0; j < 4; j++) begin
      got = (got_q.size() > g0 + j) ? got_q[g0 + j] : 'x;
      n_tests++;
      if (got !== exp_prod(opnd_base, x0 + j)) begin
        n_fail++;
        $display("FAIL basic_res%0d: got %0h want %0h", j, got, exp_prod(opnd_base, x0 + j));
      end
    end
    @(negedge ck);
    n_tests++;
    if ({o_done, o_busy} !== 2'b00) begin
      n_fail++; $display("FAIL basic_after_done: got done,busy=%b want 00", {o_done, o_busy});
    end
    n_tests++;
    if (n_done - d0 != 1 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL basic_pulse_err: got pulses=%0d err=%b want 1,0", n_done - d0, o_err);
    end
  endtask

  task automatic test_zero();
    int x0, i0;
    logic rdy_seen;
    logic [3:0] done_trace;
    i_opnd_vld = 1'b1;
    x0 = n_xfer; i0 = n_issue;
    start_job(0);
    rdy_seen = o_opnd_rdy;
    done_trace[0] = o_done;
    n_tests++;
    if (o_busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", o_busy); end
    for (int k = 1; k < 4; k++) begin
      @(negedge ck);
      rdy_seen = rdy_seen | o_opnd_rdy;
      done_trace[k] = o_done;
    end
    n_tests++;
    if (done_trace !== 4'b0100) begin
      n_fail++; $display("FAIL zero_done_timing: got %b want 0100", done_trace);
    end
    n_tests++;
    if (rdy_seen !== 1'b0 || n_xfer != x0 || n_issue != i0) begin
      n_fail++;
      $display("FAIL zero_no_issue: got rdy=%b xfer=%0d issue=%0d want 0,0,0",
               rdy_seen, n_xfer - x0, n_issue - i0);
    end
    n_tests++;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got busy=%b want 0", o_busy); end
  endtask

  task automatic test_credit();
    int x0, g0, i0;
    bit ok;
    logic [63:0] got;
    opnd_base = 64'hFFFF_FFFF_0000_0100;
    i_opnd_vld = 1'b1; i_mul_rdy = 1'b1; i_res_rdy = 1'b0;
    x0 = n_xfer; g0 = got_q.size(); i0 = n_issue;
    start_job(40);
    repeat (40) @(negedge ck);
    n_tests++;
    if (n_issue - i0 != 16 || n_xfer - x0 != 16) begin
      n_fail++;
      $display("FAIL credit_stall: got issue=%0d xfer=%0d want 16", n_issue - i0, n_xfer - x0);
    end
    n_tests++;
    if ({o_opnd_rdy, o_res_vld} !== 2'b01) begin
      n_fail++; $display("FAIL credit_rdy: got rdy,vld=%b want 01", {o_opnd_rdy, o_res_vld});
    end
    i_res_rdy = 1'b1;
    wait_done(400, 1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL credit_done: got no done want done"); end
    n_tests++;
    if (got_q.size() - g0 != 40 || n_issue - i0 != 40) begin
      n_fail++;
      $display("FAIL credit_count: got res=%0d issue=%0d want 40", got_q.size() - g0, n_issue - i0);
    end
    for (int j = 0; j < 40; j++) begin
      got = (got_q.size() > g0 + j) ? got_q[g0 + j] : 'x;
      n_tests++;
      if (got !== exp_prod(opnd_base, x0 + j)) begin
        n_fail++;
        $display("FAIL credit_res%0d: got %0h want %0h", j, got, exp_prod(opnd_base, x0 + j));
      end
    end
    n_tests++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL credit_err: got %b want 0", o_err); end
  endtask

  task automatic test_back_to_back();
    int x0, g0, xw;
    bit ok;
    logic [63:0] got;
    opnd_base = 64'h0000_0000_0000_1234;
    i_opnd_vld = 1'b1; i_mul_rdy = 1'b1; i_res_rdy = 1'b1;
    x0 = n_xfer; g0 = got_q.size();
    start_job(8);
    repeat (2) @(negedge ck);
    i_mul_rdy = 1'b0;
    xw = n_xfer;
    for (int c = 0; c < 5; c++) begin
      @(negedge ck);
      i_opnd_vld = pat_a[c];
      i_res_rdy  = pat_b[c];
    end
    n_tests++;
    if (n_xfer != xw || o_opnd_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL mulrdy_hold: got xfers=%0d rdy=%b want 0,0", n_xfer - xw, o_opnd_rdy);
    end
    i_mul_rdy = 1'b1;
    wait_done(400, 1'b1, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL mulrdy_done: got no done want done"); end
    n_tests++;
    if (got_q.size() - g0 != 8 || n_xfer - x0 != 8) begin
      n_fail++;
      $display("FAIL mulrdy_count: got res=%0d xfer=%0d want 8", got_q.size() - g0, n_xfer - x0);
    end
    for (int j = 0; j < 8; j++) begin
      got = (got_q.size() > g0 + j) ? got_q[g0 + j] : 'x;
      n_tests++;
      if (got !== exp_prod(opnd_base, x0 + j)) begin
        n_fail++;
        $display("FAIL mulrdy_res%0d: got %0h want %0h", j, got, exp_prod(opnd_base, x0 + j));
      end
    end
    n_tests++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL mulrdy_err: got %b want 0", o_err); end
    i_opnd_vld = 1'b1; i_res_rdy = 1'b1;
  endtask

  task automatic test_spurious();
    bit ok;
    @(negedge ck);
    spur_vld = 1'b1;
    @(negedge ck);
    spur_vld = 1'b0;
    n_tests++;
    if ({o_err, o_res_vld} !== 2'b10) begin
      n_fail++; $display("FAIL spur_err: got err,vld=%b want 10", {o_err, o_res_vld});
    end
    repeat (2) @(negedge ck);
    n_tests++;
    if ({o_err, o_res_vld} !== 2'b10) begin
      n_fail++; $display("FAIL spur_sticky: got err,vld=%b want 10", {o_err, o_res_vld});
    end
    start_job(0);
    n_tests++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL spur_clear: got %b want 0", o_err); end
    wait_done(10, 1'b0, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL spur_done: got no done want done"); end
  endtask

  task automatic test_reset_mid();
    int x0, g0;
    bit ok;
    logic [63:0] got;
    opnd_base = 64'h77;
    i_opnd_vld = 1'b1; i_mul_rdy = 1'b1; i_res_rdy = 1'b1;
    x0 = n_xfer;
    start_job(10);
    for (int c = 0; c < 20 && (n_xfer - x0 < 3); c++) @(negedge ck);
    n_tests++;
    if (n_xfer - x0 != 3) begin
      n_fail++; $display("FAIL rstmid_issued: got %0d want 3", n_xfer - x0);
    end
    rst = 1'b1;
    i_opnd_vld = 1'b0;
    @(negedge ck);
    n_tests++;
    if ({o_busy, o_done, o_err, o_mul_vld, o_opnd_rdy, o_res_vld} !== 6'b0) begin
      n_fail++;
      $display("FAIL rstmid_flags: got %b want 000000",
               {o_busy, o_done, o_err, o_mul_vld, o_opnd_rdy, o_res_vld});
    end
    n_tests++;
    if ({o_mul_a, o_mul_b, o_res} !== 192'b0) begin
      n_fail++; $display("FAIL rstmid_data: got a=%0h b=%0h res=%0h want 0", o_mul_a, o_mul_b, o_res);
    end
    rst = 1'b0;
    repeat (12) @(negedge ck);
    opnd_base = 64'h500;
    i_opnd_vld = 1'b1;
    x0 = n_xfer; g0 = got_q.size();
    start_job(2);
    wait_done(100, 1'b0, ok);
    n_tests++;
    if (!ok || got_q.size() - g0 != 2) begin
      n_fail++; $display("FAIL rstmid_rerun: got done=%b res=%0d want 1,2", ok, got_q.size() - g0);
    end
    for (int j = 0; j < 2; j++) begin
      got = (got_q.size() > g0 + j) ? got_q[g0 + j] : 'x;
      n_tests++;
      if (got !== exp_prod(opnd_base, x0 + j)) begin
        n_fail++;
        $display("FAIL rstmid_res%0d: got %0h want %0h", j, got, exp_prod(opnd_base, x0 + j));
      end
    end
    n_tests++;
    if (o_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_err: got %b want 0", o_err); end
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_cnt = '0; i_opnd_vld = 1'b0;
    i_mul_rdy = 1'b1; i_res_rdy = 1'b1; spur_vld = 1'b0; opnd_base = '0;
    test_reset();
    test_basic();
    test_zero();
    test_credit();
    test_back_to_back();
    test_spurious();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
